// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared controller state encoding and width helper
package adder_ctrl_pkg;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_t;

  // Index width for a value count; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// rtl/shared_adder_arbiter.sv - round-robin front end and tag tracker for one shared registered adder
module shared_adder_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic                        add_enable,
  output logic                        add_reset,
  output logic                        add_in_ready,
  output logic [IN_WIDTH-1:0]         add_i0,
  output logic [IN_WIDTH-1:0]         add_i1,
  input  logic                        add_out_ready,
  input  logic [IN_WIDTH:0]           add_out,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [IN_WIDTH:0]           res_data,
  output logic [TAG_WIDTH-1:0]        res_tag,
  output logic                        busy,
  output logic                        seq_err
);

  ctrl_state_t          state, next_state;
  logic                 flush_cnt, next_flush_cnt;
  logic                 grant_ok;
  logic                 grant_fire;
  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [TAG_WIDTH-1:0] arb_idx;
  logic                 arb_any;
  logic                 s0_valid, s1_valid;
  logic [TAG_WIDTH-1:0] s0_tag, s1_tag;

  rr_arbiter #(
    .N(NUM_REQ),
    .W(TAG_WIDTH)
  ) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_FLUSH;
      flush_cnt <= 1'b0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
    end
  end

  // FLUSH holds the adder in reset for two cycles while it drains.
  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    add_reset      = 1'b0;
    add_enable     = enable;
    grant_ok       = 1'b0;
    case (state)
      ST_FLUSH: begin
        add_reset  = 1'b1;
        add_enable = 1'b1;
        if (flush_cnt) begin
          next_state     = ST_RUN;
          next_flush_cnt = 1'b0;
        end else begin
          next_flush_cnt = 1'b1;
        end
      end
      ST_RUN: begin
        grant_ok = enable && !clear;
      end
      default: begin
        next_state     = ST_FLUSH;
        next_flush_cnt = 1'b0;
      end
    endcase
    if (clear) begin
      next_state     = ST_FLUSH;
      next_flush_cnt = 1'b0;
    end
  end

  assign req_grant    = grant_ok ? arb_grant : '0;
  assign grant_fire   = grant_ok && arb_any;
  assign add_in_ready = |req_grant;

  always_comb begin
    add_i0 = '0;
    add_i1 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_grant[k]) begin
        add_i0 = req_a[k*IN_WIDTH +: IN_WIDTH];
        add_i1 = req_b[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (arb_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : arb_idx + TAG_WIDTH'(1);
    end
  end

  // Tag stages track the adder's two register stages so results return to their owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_valid  <= 1'b0;
      s0_tag    <= '0;
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      res_valid <= '0;
      res_data  <= '0;
      res_tag   <= '0;
      seq_err   <= 1'b0;
    end else begin
      res_valid <= '0;
      if (clear) begin
        s0_valid <= 1'b0;
        s1_valid <= 1'b0;
      end else if (enable) begin
        s0_valid <= grant_fire;
        s0_tag   <= arb_idx;
        s1_valid <= s0_valid;
        s1_tag   <= s0_tag;
        if (s1_valid) begin
          res_data          <= add_out;
          res_tag           <= s1_tag;
          res_valid[s1_tag] <= 1'b1;
        end
        if (state == ST_RUN && add_out_ready != s1_valid) seq_err <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_FLUSH) || s0_valid || s1_valid;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb/tb_shared_adder_arbiter.sv - scoreboard bench with a two-stage adder model
module tb_shared_adder_arbiter;

  localparam int W  = 10;
  localparam int N  = 4;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            enable = 1'b0;
  logic            clear = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    req_grant;
  logic            add_enable, add_reset, add_in_ready;
  logic [W-1:0]    add_i0, add_i1;
  logic            add_out_ready;
  logic [W:0]      add_out;
  logic [N-1:0]    res_valid;
  logic [W:0]      res_data;
  logic [TW-1:0]   res_tag;
  logic            busy, seq_err;

  shared_adder_arbiter #(.IN_WIDTH(W), .NUM_REQ(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_grant(req_grant),
    .add_enable(add_enable), .add_reset(add_reset), .add_in_ready(add_in_ready),
    .add_i0(add_i0), .add_i1(add_i1), .add_out_ready(add_out_ready), .add_out(add_out),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // External adder: input register then output register.
  logic         p0v = 1'b0, p1v = 1'b0, force_ready = 1'b0;
  logic [W:0]   p0s = '0, p1s = '0;
  always @(posedge clk) begin
    if (add_reset) begin
      p0v <= 1'b0; p1v <= 1'b0; p0s <= '0; p1s <= '0;
    end else if (add_enable) begin
      p0v <= add_in_ready;
      p0s <= {add_i0[W-1], add_i0} + {add_i1[W-1], add_i1};
      p1v <= p0v;
      p1s <= p0s;
    end
  end
  assign add_out_ready = p1v | force_ready;
  assign add_out       = p1s;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int tag;
    int sum;
    int target;
  } exp_t;
  exp_t q[$];

  // Reference state: flush cycles left, round-robin start, enabled-edge count.
  int flush_left = 2;
  int ptr = 0;
  int en_edges = 0;
  bit last_g = 1'b0;
  int last_k = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_left = 2;
      ptr = 0;
      last_g = 1'b0;
      q.delete();
    end else begin
      if (last_g) ptr = (last_k + 1) % N;
      last_g = 1'b0;
      if (clear) begin
        flush_left = 2;
        q.delete();
      end else if (flush_left > 0) begin
        flush_left--;
      end
      if (enable) en_edges++;
    end
  end

  bit   g_allowed;
  int   g_k, g_a, g_b;
  exp_t g_e;
  always @(negedge clk) begin
    if (!resetn) begin
      chk("grant_in_reset", {add_in_ready, req_grant}, 0);
    end else begin
      g_allowed = (flush_left == 0) && enable && !clear && (req_valid != 0);
      if (g_allowed) begin
        g_k = 0;
        for (int i = N - 1; i >= 0; i--) if (req_valid[(ptr + i) % N]) g_k = (ptr + i) % N;
        g_a = $signed(req_a[g_k*W +: W]);
        g_b = $signed(req_b[g_k*W +: W]);
        chk("grant", {add_in_ready, req_grant}, 16 | (1 << g_k));
        chk("add_ops", {add_i0, add_i1}, {req_a[g_k*W +: W], req_b[g_k*W +: W]});
        g_e.tag = g_k;
        g_e.sum = g_a + g_b;
        g_e.target = en_edges + 3;
        q.push_back(g_e);
        last_g = 1'b1;
        last_k = g_k;
      end else begin
        chk("no_grant", {add_i0, add_i1, add_in_ready, req_grant}, 0);
      end
    end
  end

  exp_t m_e;
  always @(negedge clk) begin
    if (resetn && res_valid != 0) begin
      if (q.size() == 0) begin
        chk("unexpected_res", res_valid, 0);
      end else begin
        m_e = q.pop_front();
        chk("res_valid", res_valid, 1 << m_e.tag);
        chk("res_tag", res_tag, m_e.tag);
        chk("res_data", $signed(res_data), m_e.sum);
        chk("latency", en_edges, m_e.target);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = W'($urandom);
      req_b[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_tag"}, res_tag, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_grant"}, {add_in_ready, req_grant}, 0);
    chk({tag, "_add_reset"}, add_reset, 1);
    chk({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int got36[7];
  int exp36[7] = '{0, 0, 1, 2, 4, 8, 1};
  int cnt, first;

  initial begin
    #1 resetn = 1'b0;
    req_valid = 4'hF;
    enable = 1'b1;
    rand_ops();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    resetn = 1'b1;

    // Two flush cycles, then rotating grants.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got36[i] = req_grant;
    end
    for (int i = 0; i < 7; i++) chk("rr_sequence", got36[i], exp36[i]);
    step();
    req_valid = '0;
    repeat (5) step();

    // Most-negative operands on requester 2.
    req_valid = 4'b0100;
    req_a[2*W +: W] = 10'h200;
    req_b[2*W +: W] = 10'h200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("neg_res_valid", res_valid, 4);
        chk("neg_res_data", $signed(res_data), -1024);
        chk("neg_res_tag", res_tag, 2);
      end
      step();
      if (i == 0) req_valid = '0;
    end

    // Enable low for two cycles stretches the latency.
    req_valid = 4'b0010;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid != 0) begin
        cnt++;
        if (first < 0) first = i;
      end
      step();
      if (i == 0) begin
        req_valid = '0;
        enable = 1'b0;
      end
      if (i == 2) enable = 1'b1;
    end
    chk("stall_count", cnt, 1);
    chk("stall_cycle", first, 5);

    // Clear with two operations in flight.
    req_valid = 4'b0001;
    step();
    step();
    req_valid = '0;
    clear = 1'b1;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (res_valid != 0) cnt++;
      if (i == 1) chk("flush_busy", busy, 1);
      if (i == 3) chk("post_flush_busy", busy, 0);
      step();
      if (i == 0) clear = 1'b0;
    end
    chk("clear_drops", cnt, 0);
    chk("clear_seq_err", seq_err, 0);

    // Randomized traffic with stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      rand_ops();
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0;
    enable = 1'b1;
    chk("random_seq_err", seq_err, 0);

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk_reset_outputs("async_reset");
    step();
    resetn = 1'b1;
    repeat (20) begin
      req_valid = N'($urandom);
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (8) step();
    chk("drained", q.size(), 0);
    chk("drain_seq_err", seq_err, 0);

    // Adder claims a result nobody issued.
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    @(negedge clk);
    chk("seq_err_set", seq_err, 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    chk("seq_err_sticky", seq_err, 1);
    resetn = 1'b0;
    #1 chk("seq_err_reset", seq_err, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_adder_arbiter.md
SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

Interface
REQ-001 Parameter IN_WIDTH, 10, signed operand width; adder result width is IN_WIDTH+1.
REQ-002 Parameter NUM_REQ, 4, number of requesters, 2..16.
REQ-003 Parameter TAG_WIDTH, clog2(NUM_REQ), requester index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  global advance; low freezes arbiter, tag pipeline and adder.
REQ-007 clear  in  1  synchronous soft flush; drops all in-flight operations.
REQ-008 req_valid  in  NUM_REQ  per-requester add request.
REQ-009 req_a, req_b  in  NUM_REQ*IN_WIDTH  flattened signed operands; requester k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-010 req_grant  out  NUM_REQ  one-hot combinational grant; operands consumed when grant high.
REQ-011 add_enable, add_reset, add_in_ready  out  1 each  drive the shared registered adder.
REQ-012 add_i0, add_i1  out  IN_WIDTH  operands to adder.
REQ-013 add_out_ready  in  1; add_out  in  IN_WIDTH+1  adder result handshake.
REQ-014 res_valid  out  NUM_REQ  one-hot, one-cycle result strobe to owner.
REQ-015 res_data  out  IN_WIDTH+1  registered signed sum; res_tag  out  TAG_WIDTH  owner index.
REQ-016 busy  out  1  high while any tag-pipeline stage valid or state is FLUSH.
REQ-017 seq_err  out  1  sticky: adder handshake disagreed with tag pipeline.

Function
REQ-018 States SHALL be FLUSH and RUN; FLUSH holds add_reset=1, add_enable=1, no grants, for exactly 2 cycles via a 1-bit counter, then RUN.
REQ-019 clear in any state SHALL enter FLUSH next edge, invalidate both tag stages and suppress res_valid; clear has priority over grant in the same cycle.
REQ-020 In RUN, add_enable SHALL equal enable, and add_reset SHALL be 0.
REQ-021 Grant SHALL occur only when state=RUN, enable=1, clear=0 and at least one req_valid; at most one grant per cycle.
REQ-022 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, wrapping NUM_REQ-1 to 0; on grant to k, rr_ptr<=k+1 mod NUM_REQ; no grant, pointer holds.
REQ-023 add_in_ready SHALL equal OR of req_grant; add_i0/add_i1 SHALL be the granted requester's operands, zero when no grant.
REQ-024 Tag pipeline: stage0 {valid,tag} captured on each enabled edge (valid = grant); stage1 <= stage0 on enabled edges; both hold when enable=0.
REQ-025 On an enabled edge with stage1 valid, res_data<=add_out, res_tag<=stage1 tag, res_valid[tag]=1 for the following cycle only.
REQ-026 res_valid SHALL clear on the next clock edge regardless of enable; res_data/res_tag hold until next capture.
REQ-027 Latency: grant in cycle t -> res_valid high in cycle t+3 with enable continuously high; each enable-low cycle adds one.
REQ-028 Full throughput: back-to-back grants every cycle SHALL produce back-to-back results.
REQ-029 seq_err SHALL set on any enabled RUN edge where add_out_ready != stage1 valid; cleared only by resetn.
REQ-030 Sum is IN_WIDTH+1 signed, no saturation; no overflow possible.

Reset
REQ-031 resetn low SHALL asynchronously force: state=FLUSH, flush counter=0, rr_ptr=0, tag stages invalid, res_valid=0, res_data=0, res_tag=0, seq_err=0.
REQ-032 During resetn low, req_grant=0, add_in_ready=0, add_reset=1; after release, 2 FLUSH cycles precede first possible grant.

Structure
REQ-033 State encoding and clog2 helper SHALL live in a shared package adder_ctrl_pkg.
REQ-034 Round-robin selection SHALL be one sub-module rr_arbiter (req, ptr -> one-hot grant, index).
REQ-035 The shared adder SHALL be external; this block instantiates no arithmetic.

Verification
REQ-036 Reset release, req_valid=4'b1111, enable=1 -> no grant for 2 cycles, then grants 0,1,2,3,0 on successive cycles.
REQ-037 Requester 2 a=-512,b=-512 (IN_WIDTH=10) -> res_valid=4'b0100, res_data=-1024, res_tag=2, 3 cycles after grant.
REQ-038 Grant req 1 then enable=0 for 2 cycles -> result delayed 2 cycles, single-cycle res_valid, no duplicate.
REQ-039 clear asserted with 2 operations in flight -> no res_valid for them, 2 FLUSH cycles, busy=0 afterwards, seq_err=0.
REQ-040 Model adder forcing add_out_ready=1 without issue -> seq_err=1 and stays set until resetn.
REQ-041 resetn asserted mid-stream -> all outputs reach reset values without a clock edge.
